// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: IF-stage front end that owns the PC.
//   It issues in-order instruction-memory requests and prefetches into a DEPTH-entry FIFO.
//   The FIFO head is presented to IF/ID through a valid/ready handshake.
//   A redirect flushes the FIFO and discards any responses that are still in flight.
//
// Ports
//   clk_i, reset_i        clock; asynchronous active-high reset
//   enable_i              0 blocks new requests; responses and pops still proceed
//   imem_req_o/addr_o     request (memory always accepts), word-aligned address
//   imem_rvalid_i/rdata_i in-order responses
//   redirect_i/pc_i       one-cycle flush and refetch from redirect_pc_i
//   id_ready_i            IF/ID can accept
//   id_valid_o/instr_o/pc4_o  registered FIFO head
//   stat_stall_cnt_o, stat_drop_cnt_o  only when FETCH_QUEUE_STAT_EN is defined
//
// Optional feature macro: FETCH_QUEUE_STAT_EN (saturating stall/drop counters).

`timescale 1ns/1ps

module fetch_queue_unit #(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              id_ready_i,
  output logic              id_valid_o,
  output logic [DATA_W-1:0] id_instr_o,
  output logic [ADDR_W-1:0] id_pc4_o
`ifdef FETCH_QUEUE_STAT_EN
  ,
  output logic [31:0]       stat_stall_cnt_o,
  output logic [31:0]       stat_drop_cnt_o
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ResetPcAl = RESET_PC & AlignMask;
  localparam logic [CntW:0]     DepthC    = (CntW + 1)'(DEPTH);

  // Held low while in reset, so the first request lands in the cycle after the first
  // edge that follows reset release.
  logic              started_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [CntW-1:0]   out_q, out_d;
  logic [CntW-1:0]   drop_q, drop_d;
  logic [PtrW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [PtrW-1:0]   twr_q, twr_d, trd_q, trd_d;

  logic [DATA_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc4_mem_q   [DEPTH];
  // Address of every in-flight request, popped in response order.
  logic [ADDR_W-1:0] tag_mem_q   [DEPTH];

  logic issue, resp_ok, discard, push, pop;

  always_comb begin
    issue   = started_q & enable_i & ~redirect_i &
              (({1'b0, count_q} + {1'b0, out_q}) < DepthC);
    // A response with nothing outstanding is a protocol error and is ignored.
    resp_ok = imem_rvalid_i & (out_q != '0);
    // A response in the redirect cycle belongs to the old path as well.
    discard = resp_ok & (redirect_i | (drop_q != '0));
    push    = resp_ok & ~discard;
    pop     = id_valid_o & id_ready_i & ~redirect_i;
  end

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    out_d   = out_q + CntW'(issue) - CntW'(resp_ok);
    drop_d  = drop_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    twr_d   = twr_q + PtrW'(issue);
    trd_d   = trd_q + PtrW'(resp_ok);
    if (redirect_i) begin
      pc_d    = redirect_pc_i & AlignMask;
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
      // Everything still outstanding after this cycle is on the old path.
      drop_d  = out_q - CntW'(resp_ok);
    end else begin
      if (issue) begin
        pc_d = pc_q + ADDR_W'(4);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
      wr_d    = wr_q + PtrW'(push);
      rd_d    = rd_q + PtrW'(pop);
      drop_d  = drop_q - CntW'(discard);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      started_q <= 1'b0;
      pc_q      <= ResetPcAl;
      count_q   <= '0;
      out_q     <= '0;
      drop_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      twr_q     <= '0;
      trd_q     <= '0;
    end else begin
      started_q <= 1'b1;
      pc_q      <= pc_d;
      count_q   <= count_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      twr_q     <= twr_d;
      trd_q     <= trd_d;
    end
  end

  // Storage arrays need no reset: the outputs are gated by the reset-cleared count.
  always_ff @(posedge clk_i) begin
    if (issue) begin
      tag_mem_q[twr_q] <= pc_q;
    end
    if (push) begin
      instr_mem_q[wr_q] <= imem_rdata_i;
      pc4_mem_q[wr_q]   <= tag_mem_q[trd_q] + ADDR_W'(4);
    end
  end

  always_comb begin
    imem_req_o  = issue;
    imem_addr_o = pc_q;
    id_valid_o  = (count_q != '0);
    id_instr_o  = id_valid_o ? instr_mem_q[rd_q] : '0;
    id_pc4_o    = id_valid_o ? pc4_mem_q[rd_q]   : '0;
  end

`ifdef FETCH_QUEUE_STAT_EN
  logic [31:0] stall_cnt_q, drop_cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (id_valid_o && !id_ready_i && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (discard && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + 32'd1;
      end
    end
  end

  assign stat_stall_cnt_o = stall_cnt_q;
  assign stat_drop_cnt_o  = drop_cnt_q;
`endif

endmodule
